// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite register slave: bus widths, response
// codes and the write/read channel state encodings.
package axi_lite_pkg;

    localparam int unsigned REG_W  = 32;
    localparam int unsigned STRB_W = REG_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    function automatic logic [1:0] resp_for(input logic hit);
        return hit ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// Register storage: NUM_REGS x 32 bits, byte-enable synchronous write,
// registered read port, synchronous clear of every entry and the read register.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter  int unsigned NUM_REGS = 16,
    localparam int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [REG_W-1:0]  wr_data,
    input  logic [STRB_W-1:0] wr_strb,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [REG_W-1:0]  rd_data
);

    logic [REG_W-1:0] mem [NUM_REGS];

    // NOTE: storage is cleared by reset because software may read any register
    // straight after reset and must see zero, so it stays in flops, not a RAM macro.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // A read issued on the same edge as a write returns the old contents.
    always_ff @(posedge clk) begin
        if (clear) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave exposing C_NUM_REGS 32-bit registers at C_BASE_ADDR;
// independent write and read channels, one transaction outstanding on each.
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_NUM_REGS         = 16,
    parameter logic [31:0] C_BASE_ADDR        = 32'h8800_0000
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY
);

    localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned IDX_W = $clog2(C_NUM_REGS);
    localparam logic [AW-1:0] BASE = AW'(C_BASE_ADDR);

    if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
        $error("axi_lite_slave_regs supports only a 32-bit data bus");
    end
    if (C_NUM_REGS < 2 || C_NUM_REGS > 256 || (1 << IDX_W) != C_NUM_REGS) begin : g_bad_num_regs
        $error("C_NUM_REGS must be a power of two in 2..256");
    end
    if (AW < IDX_W + 2) begin : g_bad_addr_width
        $error("address bus too narrow for the register window");
    end

    w_state_t w_state, w_state_nx;
    r_state_t r_state, r_state_nx;

    logic              ready_en;
    logic              aw_held, w_held;
    logic [AW-1:0]     awaddr_q;
    logic [REG_W-1:0]  wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [1:0]        bresp_q;
    logic [1:0]        rresp_q;
    logic              r_hit;

    logic              awready_c, wready_c, arready_c;
    logic              aw_hs, w_hs, ar_hs, commit;
    logic [AW-1:0]     wr_addr, wr_off, rd_off;
    logic [REG_W-1:0]  wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic              wr_hit, rd_hit;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic [REG_W-1:0]  rf_rdata;

    // Write channel: the transaction uses whichever of AW/W was latched
    // earlier, or the live bus value when its handshake completes now.
    assign wr_addr = aw_held ? awaddr_q : S_AXI_AWADDR;
    assign wr_data = w_held  ? wdata_q  : S_AXI_WDATA;
    assign wr_strb = w_held  ? wstrb_q  : S_AXI_WSTRB;
    assign wr_off  = wr_addr - BASE;
    assign wr_hit  = (wr_off >> (IDX_W + 2)) == '0;
    assign wr_idx  = wr_off[IDX_W+1:2];

    assign rd_off  = S_AXI_ARADDR - BASE;
    assign rd_hit  = (rd_off >> (IDX_W + 2)) == '0;
    assign rd_idx  = rd_off[IDX_W+1:2];

    assign aw_hs = S_AXI_AWVALID && awready_c;
    assign w_hs  = S_AXI_WVALID  && wready_c;
    assign ar_hs = S_AXI_ARVALID && arready_c;

    // NOTE: every signal driven here gets a default first so that no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        w_state_nx = w_state;
        awready_c  = 1'b0;
        wready_c   = 1'b0;
        commit     = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready_c = ready_en && !aw_held;
                wready_c  = ready_en && !w_held;
                if ((aw_held || (S_AXI_AWVALID && awready_c)) &&
                    (w_held  || (S_AXI_WVALID  && wready_c))) begin
                    commit     = 1'b1;
                    w_state_nx = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_state_nx = W_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        r_state_nx = r_state;
        arready_c  = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready_c = ready_en;
                if (S_AXI_ARVALID && arready_c) begin
                    r_state_nx = R_DATA;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    r_state_nx = R_IDLE;
                end
            end
        endcase
    end

    // Keeps the READYs low for one cycle after reset is released.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_state  <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            w_state <= w_state_nx;
            if (aw_hs) begin
                aw_held  <= 1'b1;
                awaddr_q <= S_AXI_AWADDR;
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (commit) begin
                bresp_q <= resp_for(wr_hit);
            end
            if (w_state == W_RESP && S_AXI_BREADY) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state <= R_IDLE;
            r_hit   <= 1'b0;
            rresp_q <= RESP_OKAY;
        end else begin
            r_state <= r_state_nx;
            if (ar_hs) begin
                r_hit   <= rd_hit;
                rresp_q <= resp_for(rd_hit);
            end
        end
    end

    axi_lite_regfile #(
        .NUM_REGS (C_NUM_REGS)
    ) u_regfile (
        .clk     (S_AXI_ACLK),
        .clear   (S_AXI_ARESET),
        .wr_en   (commit && wr_hit),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .rd_en   (ar_hs && rd_hit),
        .rd_idx  (rd_idx),
        .rd_data (rf_rdata)
    );

    assign S_AXI_AWREADY = awready_c;
    assign S_AXI_WREADY  = wready_c;
    assign S_AXI_BVALID  = (w_state == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_c;
    assign S_AXI_RVALID  = (r_state == R_DATA);
    assign S_AXI_RRESP   = rresp_q;
    // A miss leaves the read register untouched, so mask it to return zero.
    assign S_AXI_RDATA   = r_hit ? rf_rdata : '0;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_off[1:0], rd_off[1:0]};

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for axi_lite_slave_regs: vector table through a response
// scoreboard, plus hand-written sequences for ordering, backpressure and reset.
module tb_axi_lite_slave_regs;

    localparam logic [31:0] BASE    = 32'h8800_0000;
    localparam logic [1:0]  OKAY    = 2'b00;
    localparam logic [1:0]  SLVERR  = 2'b10;
    localparam int          TIMEOUT = 50;

    logic        S_AXI_ACLK;
    logic        S_AXI_ARESET;
    logic [31:0] S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [31:0] S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    axi_lite_slave_regs dut (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESET  (S_AXI_ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY)
    );

    initial S_AXI_ACLK = 1'b0;
    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    vec_t vecs[$];
    exp_t b_q[$];
    exp_t r_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, actual, expected);
        end
    endtask

    function automatic void add_wr(input logic [31:0] addr, input logic [31:0] data,
                                   input logic [3:0] strb, input logic [1:0] resp);
        vecs.push_back('{is_write: 1'b1, addr: addr, data: data, strb: strb,
                         exp_resp: resp, exp_rdata: 32'd0});
    endfunction

    function automatic void add_rd(input logic [31:0] addr, input logic [31:0] rdata,
                                   input logic [1:0] resp);
        vecs.push_back('{is_write: 1'b0, addr: addr, data: 32'd0, strb: 4'h0,
                         exp_resp: resp, exp_rdata: rdata});
    endfunction

    // Tasks start and end on a falling edge; outputs are sampled there.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp, input string tag);
        exp_t e;
        int   cnt;
        logic aw_fire, w_fire;
        b_q.push_back('{resp: exp_resp, data: 32'd0});
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        cnt = 0;
        while ((S_AXI_AWVALID || S_AXI_WVALID) && cnt < TIMEOUT) begin
            aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
            w_fire  = S_AXI_WVALID && S_AXI_WREADY;
            @(negedge S_AXI_ACLK);
            if (aw_fire) S_AXI_AWVALID = 1'b0;
            if (w_fire)  S_AXI_WVALID  = 1'b0;
            cnt++;
        end
        if (S_AXI_AWVALID) check({tag, " awready"}, 32'(S_AXI_AWREADY), 32'd1);
        if (S_AXI_WVALID)  check({tag, " wready"},  32'(S_AXI_WREADY),  32'd1);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b1;
        cnt = 0;
        while (!S_AXI_BVALID && cnt < TIMEOUT) begin
            @(negedge S_AXI_ACLK);
            cnt++;
        end
        e = b_q.pop_front();
        check({tag, " bvalid"}, 32'(S_AXI_BVALID), 32'd1);
        if (S_AXI_BVALID) check({tag, " bresp"}, 32'(S_AXI_BRESP), 32'(e.resp));
        @(negedge S_AXI_ACLK);
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input string tag);
        exp_t e;
        int   cnt;
        logic ar_fire;
        r_q.push_back('{resp: exp_resp, data: exp_data});
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        cnt = 0;
        while (S_AXI_ARVALID && cnt < TIMEOUT) begin
            ar_fire = S_AXI_ARREADY;
            @(negedge S_AXI_ACLK);
            if (ar_fire) S_AXI_ARVALID = 1'b0;
            cnt++;
        end
        if (S_AXI_ARVALID) check({tag, " arready"}, 32'(S_AXI_ARREADY), 32'd1);
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        cnt = 0;
        while (!S_AXI_RVALID && cnt < TIMEOUT) begin
            @(negedge S_AXI_ACLK);
            cnt++;
        end
        e = r_q.pop_front();
        check({tag, " rvalid"}, 32'(S_AXI_RVALID), 32'd1);
        if (S_AXI_RVALID) begin
            check({tag, " rdata"}, S_AXI_RDATA, e.data);
            check({tag, " rresp"}, 32'(S_AXI_RRESP), 32'(e.resp));
        end
        @(negedge S_AXI_ACLK);
        S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        S_AXI_ARESET  = 1'b1;
        S_AXI_AWADDR  = '0;
        S_AXI_AWPROT  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARADDR  = '0;
        S_AXI_ARPROT  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;

        // Reset state
        repeat (3) @(negedge S_AXI_ACLK);
        check("rst readies", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd0);
        check("rst valids",  32'({S_AXI_BVALID, S_AXI_RVALID}), 32'd0);
        check("rst rdata",   S_AXI_RDATA, 32'd0);
        check("rst resps",   32'({S_AXI_BRESP, S_AXI_RRESP}), 32'd0);
        S_AXI_ARESET = 1'b0;
        check("release readies low", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd0);
        @(negedge S_AXI_ACLK);
        check("release readies high", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'h7);

        // Vector table
        for (int i = 1; i <= 16; i++) add_wr(BASE + 32'((i - 1) * 4), 32'(i), 4'hF, OKAY);
        for (int i = 1; i <= 16; i++) add_rd(BASE + 32'((i - 1) * 4), 32'(i), OKAY);
        add_wr(32'h8800_0040, 32'hDEAD_BEEF, 4'hF, SLVERR);
        add_wr(32'h87FF_FFFC, 32'hBAD0_BAD0, 4'hF, SLVERR);
        add_rd(32'h8800_0040, 32'd0, SLVERR);
        add_rd(32'h87FF_FFFC, 32'd0, SLVERR);
        for (int i = 1; i <= 16; i++) add_rd(BASE + 32'((i - 1) * 4), 32'(i), OKAY);
        add_rd(32'h8800_003F, 32'd16, OKAY);
        add_wr(BASE, 32'hFFFF_FFFF, 4'hF, OKAY);
        add_wr(BASE, 32'h1234_5678, 4'b0011, OKAY);
        add_rd(BASE, 32'hFFFF_5678, OKAY);
        add_wr(BASE + 32'h4, 32'hAAAA_AAAA, 4'b0000, OKAY);
        add_rd(BASE + 32'h4, 32'd2, OKAY);
        add_wr(BASE + 32'h8, 32'h1122_3344, 4'b1100, OKAY);
        add_rd(BASE + 32'h8, 32'h1122_0003, OKAY);

        foreach (vecs[k]) begin
            if (vecs[k].is_write)
                do_write(vecs[k].addr, vecs[k].data, vecs[k].strb, vecs[k].exp_resp,
                         $sformatf("vec%0d wr", k));
            else
                do_read(vecs[k].addr, vecs[k].exp_rdata, vecs[k].exp_resp,
                        $sformatf("vec%0d rd", k));
        end

        // W leads AW by three cycles, then BREADY held low for five cycles
        S_AXI_WDATA  = 32'hCAFE_F00D;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        check("wfirst wready", 32'(S_AXI_WREADY), 32'd1);
        @(negedge S_AXI_ACLK);
        S_AXI_WVALID = 1'b0;
        for (int c = 0; c < 2; c++) begin
            check("wfirst held", 32'({S_AXI_WREADY, S_AXI_AWREADY, S_AXI_BVALID}), 32'b010);
            @(negedge S_AXI_ACLK);
        end
        S_AXI_AWADDR  = BASE + 32'h14;
        S_AXI_AWVALID = 1'b1;
        check("wfirst awready", 32'(S_AXI_AWREADY), 32'd1);
        @(negedge S_AXI_ACLK);
        S_AXI_AWVALID = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bhold c%0d", c),
                  32'({S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY}), 32'b10000);
            @(negedge S_AXI_ACLK);
        end
        S_AXI_BREADY = 1'b1;
        @(negedge S_AXI_ACLK);
        S_AXI_BREADY = 1'b0;
        check("bhold done", 32'({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}), 32'b011);
        do_read(BASE + 32'h14, 32'hCAFE_F00D, OKAY, "wfirst readback");

        // Read captured on the same edge as a write to the same register
        S_AXI_AWADDR  = BASE + 32'hC;
        S_AXI_WDATA   = 32'h0000_0055;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_ARADDR  = BASE + 32'hC;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARVALID = 1'b1;
        check("same-edge readies", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'h7);
        @(negedge S_AXI_ACLK);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        check("same-edge valids", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'b11);
        check("same-edge old rdata", S_AXI_RDATA, 32'd4);
        S_AXI_BREADY = 1'b1;
        S_AXI_RREADY = 1'b1;
        @(negedge S_AXI_ACLK);
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        check("same-edge done", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'b00);
        do_read(BASE + 32'hC, 32'h0000_0055, OKAY, "same-edge new");

        // Reset with a write response and a read response both pending
        S_AXI_AWADDR  = BASE + 32'h1C;
        S_AXI_WDATA   = 32'h0000_0077;
        S_AXI_ARADDR  = BASE + 32'h20;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARVALID = 1'b1;
        @(negedge S_AXI_ACLK);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        check("pre-reset valids", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'b11);
        S_AXI_ARESET = 1'b1;
        @(negedge S_AXI_ACLK);
        check("mid-reset valids", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'b00);
        check("mid-reset rdata", S_AXI_RDATA, 32'd0);
        S_AXI_ARESET = 1'b0;
        @(negedge S_AXI_ACLK);
        for (int i = 0; i < 16; i++) do_read(BASE + 32'(i * 4), 32'd0, OKAY, $sformatf("post-reset r%0d", i));

        check("scoreboard empty", 32'(b_q.size() + r_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_regs.md
AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs
Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, address bus width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-003 SHALL have parameter C_NUM_REGS, default 16, number of 32-bit registers (power of two, 2..256).
REQ-004 SHALL have parameter C_BASE_ADDR, default 32'h88000000, byte address of register 0.
REQ-005 SHALL have port S_AXI_ACLK  in  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port S_AXI_ARESET  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
REQ-008 SHALL have port S_AXI_AWPROT  in  3  write protection; ignored.
REQ-009 SHALL have port S_AXI_AWVALID  in  1  write address valid.
REQ-010 SHALL have port S_AXI_AWREADY  out  1  write address ready.
REQ-011 SHALL have port S_AXI_WDATA  in  32  write data.
REQ-012 SHALL have port S_AXI_WSTRB  in  4  byte write strobes.
REQ-013 SHALL have port S_AXI_WVALID  in  1  write data valid.
REQ-014 SHALL have port S_AXI_WREADY  out  1  write data ready.
REQ-015 SHALL have port S_AXI_BRESP  out  2  write response.
REQ-016 SHALL have port S_AXI_BVALID  out  1  write response valid.
REQ-017 SHALL have port S_AXI_BREADY  in  1  write response ready.
REQ-018 SHALL have port S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
REQ-019 SHALL have port S_AXI_ARPROT  in  3  read protection; ignored.
REQ-020 SHALL have port S_AXI_ARVALID  in  1  read address valid.
REQ-021 SHALL have port S_AXI_ARREADY  out  1  read address ready.
REQ-022 SHALL have port S_AXI_RDATA  out  32  read data.
REQ-023 SHALL have port S_AXI_RRESP  out  2  read response.
REQ-024 SHALL have port S_AXI_RVALID  out  1  read data valid.
REQ-025 SHALL have port S_AXI_RREADY  in  1  read data ready.
Function
REQ-026 Decode: offset = ADDR - C_BASE_ADDR (modulo 2^width); hit when offset < C_NUM_REGS*4; index = offset[log2(C_NUM_REGS)+1:2]; ADDR[1:0] ignored.
REQ-027 Write FSM states W_IDLE, W_RESP; in W_IDLE AWREADY = !aw_held, WREADY = !w_held; AW and W accepted independently, in either order or the same cycle, each latched until both are held.
REQ-028 At the edge where the second of AW/W handshakes completes (or both together): hit -> bytes with WSTRB[i]=1 written, BRESP=OKAY(00); miss -> no write, BRESP=SLVERR(10); FSM -> W_RESP, BVALID=1 next cycle.
REQ-029 In W_RESP: AWREADY=WREADY=0; BVALID and BRESP held stable until BREADY=1; at that edge BVALID=0, held flags cleared, FSM -> W_IDLE; at most one write outstanding.
REQ-030 Read FSM states R_IDLE, R_DATA; ARREADY=1 only in R_IDLE; on AR handshake edge RDATA/RRESP registered (hit: register value, OKAY; miss: 0, SLVERR), RVALID=1 next cycle.
REQ-031 In R_DATA: RVALID, RDATA, RRESP held stable until RREADY=1; at that edge RVALID=0, FSM -> R_IDLE; next AR accepted no earlier than the following cycle.
REQ-032 Read and write channels independent; a read captured at the same edge as a write commit to the same register SHALL return the pre-write value.
REQ-033 WSTRB=0000 with hit: no bytes change, BRESP=OKAY.
Reset
REQ-034 While S_AXI_ARESET=1 at an edge: AWREADY, WREADY, BVALID, ARREADY, RVALID = 0; BRESP, RRESP, RDATA = 0; FSMs -> idle; held flags cleared; all registers = 0; in-flight transactions discarded. Handshake READYs rise one cycle after reset release.
Structure
REQ-035 Shared package axi_lite_pkg SHALL hold response codes (OKAY=2'b00, SLVERR=2'b10) and the W_/R_ state encodings.
REQ-036 Storage SHALL be sub-module axi_lite_regfile: C_NUM_REGS x 32, byte-enable synchronous write, registered read, synchronous active-high clear.
Verification
REQ-037 Write index i (1..16) to 0x88000000+(i-1)*4, then read all back -> each BRESP=00, RDATA=i, RRESP=00.
REQ-038 Write/read 0x88000040 and 0x87FFFFFC -> BRESP=10, RDATA=0, RRESP=10, no register modified.
REQ-039 Reg 0 = 0xFFFFFFFF, write 0x12345678 with WSTRB=0011 -> readback 0xFFFF5678.
REQ-040 WVALID 3 cycles before AWVALID, and BREADY low 5 cycles -> write once, BVALID held 5 cycles, AWREADY/WREADY low throughout.
REQ-041 Assert S_AXI_ARESET during W_RESP and R_DATA -> BVALID=RVALID=0 next cycle, all registers read back 0.
